// File: rtl/dht11_pkg.sv
// Shared types, default timings and helpers for the DHT11 responder.
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      RESP_WAIT,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      END_LOW
   } state_t;

   localparam int DEF_CLK_FREQ_HZ  = 100_000_000;
   localparam int DEF_START_MIN_US = 18000;
   localparam int DEF_RESP_WAIT_US = 30;
   localparam int DEF_RESP_LOW_US  = 80;
   localparam int DEF_RESP_HIGH_US = 80;
   localparam int DEF_BIT_LOW_US   = 50;
   localparam int DEF_BIT0_HIGH_US = 28;
   localparam int DEF_BIT1_HIGH_US = 70;

   // Bit 39 of the packed frame is hum_int[7].
   typedef struct packed {
      logic [7:0] hum_int;
      logic [7:0] hum_frac;
      logic [7:0] temp_int;
      logic [7:0] temp_frac;
      logic [7:0] chk;
   } dht11_frame_t;

   function automatic int us_to_cycles(input int us, input int clk_hz);
      return us * (clk_hz / 1_000_000);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the shared data line with edge strobes.
module dht11_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic data_i,
   output logic fall_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Flops reset high so an idle line never shows a false edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= (data_i !== 1'b0);
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign fall_o = prev_q & ~sync_q;
   assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 responder: answers a host start pulse with the response
// preamble and a 40-bit humidity/temperature frame.
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
   parameter int START_MIN_US = DEF_START_MIN_US,
   parameter int RESP_WAIT_US = DEF_RESP_WAIT_US,
   parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
   parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
   parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
   parameter int BIT0_HIGH_US = DEF_BIT0_HIGH_US,
   parameter int BIT1_HIGH_US = DEF_BIT1_HIGH_US,
   parameter bit LSB_FIRST    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic [7:0] hum_int_i,
   input  logic [7:0] hum_frac_i,
   input  logic [7:0] temp_int_i,
   input  logic [7:0] temp_frac_i,
   input  logic       corrupt_chk_i,
   input  logic       dht11_data_i,
   output logic       dht11_data_o,
   output logic       dht11_data_o_en,
   output logic       busy_o,
   output logic       start_seen_o,
   output logic       frame_done_o
);

   localparam int START_C = us_to_cycles(START_MIN_US, CLK_FREQ_HZ);
   localparam int RW_C    = us_to_cycles(RESP_WAIT_US, CLK_FREQ_HZ);
   localparam int RL_C    = us_to_cycles(RESP_LOW_US, CLK_FREQ_HZ);
   localparam int RH_C    = us_to_cycles(RESP_HIGH_US, CLK_FREQ_HZ);
   localparam int BL_C    = us_to_cycles(BIT_LOW_US, CLK_FREQ_HZ);
   localparam int B0_C    = us_to_cycles(BIT0_HIGH_US, CLK_FREQ_HZ);
   localparam int B1_C    = us_to_cycles(BIT1_HIGH_US, CLK_FREQ_HZ);
   localparam int MAX_C   = max_of(START_C, max_of(max_of(RW_C, RL_C),
                            max_of(max_of(RH_C, BL_C), B1_C)));
   localparam int CW      = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_C);
   localparam logic [CW-1:0] START_CV = CW'(START_C);
   localparam logic [CW-1:0] RW_M1    = CW'(RW_C - 1);
   localparam logic [CW-1:0] RL_M1    = CW'(RL_C - 1);
   localparam logic [CW-1:0] RH_M1    = CW'(RH_C - 1);
   localparam logic [CW-1:0] BL_M1    = CW'(BL_C - 1);
   localparam logic [CW-1:0] B0_M1    = CW'(B0_C - 1);
   localparam logic [CW-1:0] B1_M1    = CW'(B1_C - 1);

   localparam logic [5:0] FIRST_BIT = LSB_FIRST ? 6'd0 : 6'd39;
   localparam logic [5:0] LAST_BIT  = LSB_FIRST ? 6'd39 : 6'd0;

   state_t       state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [5:0]   bit_q, bit_d;
   dht11_frame_t frame_q, frame_d;
   logic [39:0]  frame_bits;
   logic [7:0]   sum;
   logic         cur_bit;
   logic         fall, rise;
   logic         o_d, en_d, busy_d, start_d, done_d;

   dht11_line_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .data_i (dht11_data_i),
      .fall_o (fall),
      .rise_o (rise)
   );

   assign frame_bits = frame_q;
   assign cur_bit    = frame_bits[bit_q];
   assign sum        = hum_int_i + hum_frac_i + temp_int_i + temp_frac_i;
   assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      bit_d   = bit_q;
      frame_d = frame_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable_i && fall) state_d = START_LOW;
         end
         START_LOW: begin
            if (rise) begin
               cnt_d = '0;
               if (cnt_q >= START_CV) begin
                  frame_d.hum_int   = hum_int_i;
                  frame_d.hum_frac  = hum_frac_i;
                  frame_d.temp_int  = temp_int_i;
                  frame_d.temp_frac = temp_frac_i;
                  frame_d.chk       = sum ^ {8{corrupt_chk_i}};
                  state_d = RESP_WAIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RESP_WAIT: if (cnt_q == RW_M1) begin
            cnt_d   = '0;
            state_d = RESP_LOW;
         end
         RESP_LOW: if (cnt_q == RL_M1) begin
            cnt_d   = '0;
            state_d = RESP_HIGH;
         end
         RESP_HIGH: if (cnt_q == RH_M1) begin
            cnt_d   = '0;
            bit_d   = FIRST_BIT;
            state_d = BIT_LOW;
         end
         BIT_LOW: if (cnt_q == BL_M1) begin
            cnt_d   = '0;
            state_d = BIT_HIGH;
         end
         BIT_HIGH: if (cnt_q == (cur_bit ? B1_M1 : B0_M1)) begin
            cnt_d = '0;
            if (bit_q == LAST_BIT) begin
               state_d = END_LOW;
            end else begin
               bit_d   = LSB_FIRST ? bit_q + 6'd1 : bit_q - 6'd1;
               state_d = BIT_LOW;
            end
         end
         END_LOW: if (cnt_q == BL_M1) begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they move only
   // on phase boundaries.
   always_comb begin
      en_d    = state_d inside {RESP_LOW, RESP_HIGH, BIT_LOW,
                                BIT_HIGH, END_LOW};
      o_d     = state_d inside {RESP_HIGH, BIT_HIGH};
      busy_d  = !(state_d inside {IDLE, START_LOW});
      start_d = (state_q == START_LOW) && (state_d == RESP_WAIT);
      done_d  = (state_q == END_LOW) && (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         bit_q           <= '0;
         frame_q         <= '0;
         dht11_data_o    <= 1'b0;
         dht11_data_o_en <= 1'b0;
         busy_o          <= 1'b0;
         start_seen_o    <= 1'b0;
         frame_done_o    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_q           <= bit_d;
         frame_q         <= frame_d;
         dht11_data_o    <= o_d;
         dht11_data_o_en <= en_d;
         busy_o          <= busy_d;
         start_seen_o    <= start_d;
         frame_done_o    <= done_d;
      end
   end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
Synthesizable DHT11 sensor emulator, acting as the responder end of the single-wire DHT11 protocol. It detects the host start pulse and returns the 80/80 µs response preamble, then sends a 40-bit frame: humidity int, humidity frac, temperature int, temperature frac, checksum. It is used for hardware-in-loop and simulation of the DHT11 host controller on the same tri-state line, replacing the behavioural sensor model in benches.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; cycles per µs = CLK_FREQ_HZ/1_000_000.
START_MIN_US, 18000, minimum host low time accepted as a start request.
RESP_WAIT_US, 30, delay from host release (line high) to the first response low.
RESP_LOW_US, 80, response low phase.
RESP_HIGH_US, 80, response high phase.
BIT_LOW_US, 50, low lead-in before every data bit and the end marker.
BIT0_HIGH_US, 28, high time encoding '0'.
BIT1_HIGH_US, 70, high time encoding '1'.
LSB_FIRST, 0, 0 = frame bit 39 first (datasheet order); 1 = bit 0 first.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable_i  in  1  allows start detection
hum_int_i  in  8  humidity integer byte
hum_frac_i  in  8  humidity fraction byte
temp_int_i  in  8  temperature integer byte
temp_frac_i  in  8  temperature fraction byte
corrupt_chk_i  in  1  when 1, transmitted checksum is inverted (~sum)
dht11_data_i  in  1  sampled line level
dht11_data_o  out  1  level driven onto the line
dht11_data_o_en  out  1  1 = drive line, 0 = release (high-Z)
busy_o  out  1  high from accepted start until end marker released
start_seen_o  out  1  one-cycle pulse on an accepted start
frame_done_o  out  1  one-cycle pulse when the line is released after the end marker

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. A reset mid-frame releases the line (o_en = 0) on the next edge; no partial frame resumes.
- dht11_data_i passes through a 2-flop synchronizer. All timing is referenced to the synchronized level. X/Z counts as not-low.
- Timing constants are converted to cycles as US × cycles-per-µs. The shared counter width is $clog2 of the largest count (START_MIN) + 1, and it saturates at that maximum.
- IDLE: waits for enable_i && line low, then goes to START_LOW with the counter cleared.
- START_LOW: counts while the line is low.
  - Line goes high with count ≥ START_MIN cycles: latch the four bytes and checksum = (sum of 4 bytes) mod 256, XORed with 0xFF if corrupt_chk_i. Pulse start_seen_o, set busy_o, go to RESP_WAIT.
  - Line goes high with count shorter than that: return to IDLE silently.
- RESP_WAIT: RESP_WAIT cycles with the line released. The line is not monitored.
- RESP_LOW: o_en = 1, o = 0 for RESP_LOW cycles.
- RESP_HIGH: o = 1 for RESP_HIGH cycles.
- BIT_LOW: o = 0 for BIT_LOW cycles.
- BIT_HIGH: o = 1 for BIT0_HIGH or BIT1_HIGH cycles according to the current bit. Bit index decrements from 39 (or increments from 0 if LSB_FIRST). After the 40th bit go to END_LOW.
- END_LOW: o = 0 for BIT_LOW cycles, then o_en = 0, busy_o = 0, frame_done_o pulse, return to IDLE.
- In every driving state, dht11_data_o and o_en change only at phase boundaries. Phase durations are exact to ±0 cycles.
- Input changes during busy are ignored: the frame data is latched at the start. enable_i deasserting mid-frame does not abort; the frame completes.
- Line activity from the host while the responder drives is ignored.
- A new start is only detected from IDLE. The line must be seen high in IDLE before a low is counted, so the end marker cannot retrigger.

Decomposition:
- Package dht11_pkg holds:
  - the state enum (IDLE, START_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW);
  - the default µs timing constants;
  - a us_to_cycles function;
  - a dht11_frame_t packed struct of 5 bytes.
- One sub-module, dht11_line_sync: the 2-flop synchronizer plus fall/rise edge strobes.

Test Plan:
- Bytes 0x35, 0x00, 0x18, 0x00; host low for 18 ms then release → response starts after 30 µs (3000 cycles): 8000 cycles low, 8000 high. Then 40 bits MSB-first 00110101_00000000_00011000_00000000_01001101 (checksum 0x4D), each bit 5000 cycles low + 2800/7000 high, then 5000 cycles low, release, frame_done_o pulse.
- Host low for 1 ms then release → no start_seen_o, o_en stays 0, FSM returns to IDLE.
- corrupt_chk_i = 1 with the same bytes → last byte on the wire is 0xB2; first 32 bits unchanged.
- LSB_FIRST = 1 with the same bytes → first transmitted bit = bit 0 of the 40-bit frame (1 = checksum LSB), last = hum_int bit 7 (0).
- rst asserted during bit 12 → o_en = 0 next cycle, busy_o = 0. A subsequent 18 ms start produces a complete correct frame.
- Two back-to-back starts 10 µs after frame_done_o, with the bytes changed between them → the second frame carries the new bytes and checksum. Bytes changed during busy do not alter the first frame.
